prog_loader: RTL and testbench

// - Writes a program into quick CPU RAM from off-chip, driven over the TT pins (ui_in data, uio_in control).
// - Host side of the bench/board drives bytes in; this block writes them to RAM and acks each one.
// - Holds the CPU (cpu_hold) while a load is in progress, then releases it to run the new image.
// - Sits inside tt_um_quick_cpu, between the pins and the RAM write port, ahead of the CPU core.

---
 rtl/quick_cpu_pkg.sv | 18 +
 rtl/toggle_sync.sv | 32 +++
 rtl/prog_loader.sv | 126 ++++++++++++
 tb/tb_prog_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/quick_cpu_pkg.sv
// rtl/quick_cpu_pkg.sv - shared loader types and uio pin map for quick_cpu
package quick_cpu_pkg;

  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_e;

  localparam int UIO_LOAD_REQ = 0;
  localparam int UIO_STROBE   = 1;
  localparam int UIO_ACK      = 2;
  localparam int UIO_BUSY     = 3;

endpackage

// File: rtl/toggle_sync.sv
// rtl/toggle_sync.sv - multi-flop synchroniser with enable-gated change detect
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic level,
  output logic evt
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // prev_q only advances with ena, so a change seen while disabled stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      if (ena) begin
        prev_q <= sync_q[STAGES-1];
      end
    end
  end

  assign level = sync_q[STAGES-1];
  assign evt   = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - host-to-RAM program loader with toggle handshake and CPU hold
module prog_loader
  import quick_cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        ui_in,
  input  logic              load_req,
  input  logic              strobe,
  output logic              ack,
  output logic              busy,
  output logic              cpu_hold,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        checksum,
  output logic              overflow,
  output logic [7:0]        uio_oe
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        sum_q;
  logic              full_q;
  logic              ovf_q;
  logic              ack_q;
  logic              req_lvl;
  logic              stb_evt;
  logic              unused_req_evt;
  logic              unused_stb_lvl;

  toggle_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .d     (load_req),
    .level (req_lvl),
    .evt   (unused_req_evt)
  );

  toggle_sync #(.STAGES(SYNC_STAGES)) u_stb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .d     (strobe),
    .level (unused_stb_lvl),
    .evt   (stb_evt)
  );

  // a pending byte wins over load_req falling so the last byte is never lost
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_lvl) state_d = LOAD;
      LOAD: begin
        if (stb_evt)       state_d = WRITE;
        else if (!req_lvl) state_d = DONE;
      end
      WRITE:   state_d = LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sum_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (req_lvl) begin
            addr_q <= '0;
            sum_q  <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
          end
        end
        LOAD: begin
          if (stb_evt) wdata_q <= ui_in;
        end
        WRITE: begin
          ack_q <= ~ack_q;
          if (full_q) begin
            ovf_q <= 1'b1;
          end else begin
            sum_q <= sum_q + wdata_q;
            // park on the last address instead of wrapping
            if (addr_q == ADDR_MAX) full_q <= 1'b1;
            else                    addr_q <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    uio_oe           = '0;
    uio_oe[UIO_ACK]  = 1'b1;
    uio_oe[UIO_BUSY] = 1'b1;
  end

  assign mem_we    = (state_q == WRITE) && !full_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign checksum  = sum_q;
  assign overflow  = ovf_q;
  assign ack       = ack_q;
  assign busy      = (state_q == LOAD) || (state_q == WRITE);
  assign cpu_hold  = (state_q != IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic       load_req;
  logic       strobe;
  logic       ack, busy, cpu_hold, mem_we, overflow;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, checksum, uio_oe;

  logic [7:0] ram [0:31];
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int ack_cnt = 0;
  logic ack_prev = 1'b0;
  int we_base, ack_base, lat;
  logic seen;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .ui_in     (ui_in),
    .load_req  (load_req),
    .strobe    (strobe),
    .ack       (ack),
    .busy      (busy),
    .cpu_hold  (cpu_hold),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .checksum  (checksum),
    .overflow  (overflow),
    .uio_oe    (uio_oe)
  );

  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cnt++;
    if (ack !== ack_prev) ack_cnt++;
    ack_prev = ack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ui_in  = b;
    strobe = ~strobe;
    repeat (6) @(negedge clk);
  endtask

  task automatic open_session();
    @(negedge clk);
    load_req = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic close_session(input string tag);
    logic found;
    found = 1'b0;
    @(negedge clk);
    load_req = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (cpu_hold && !busy) found = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, found}, 32'd1);
    @(negedge clk);
    check({tag, "_hold_release"}, {31'd0, cpu_hold}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; load_req = 1'b0; strobe = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hold",     {31'd0, cpu_hold}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_ack",      {31'd0, ack},      32'd0);
    check("rst_we",       {31'd0, mem_we},   32'd0);
    check("rst_addr",     {27'd0, mem_addr}, 32'd0);
    check("rst_checksum", {24'd0, checksum}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("uio_oe",       {24'd0, uio_oe},   32'h0C);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // idle noise
    we_base = we_cnt; ack_base = ack_cnt;
    send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
    check("idle_no_we",  we_cnt - we_base,   0);
    check("idle_no_ack", ack_cnt - ack_base, 0);
    check("idle_hold",   {31'd0, cpu_hold},  32'd0);

    // basic load with latency measurement on the first byte
    we_base = we_cnt; ack_base = ack_cnt;
    open_session();
    check("basic_hold", {31'd0, cpu_hold}, 32'd1);
    check("basic_busy", {31'd0, busy},     32'd1);
    @(negedge clk);
    ui_in = 8'h11; strobe = ~strobe;
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (mem_we) begin seen = 1'b1; lat = k; end
    end
    check("latency_we", lat, 3);
    repeat (6) @(negedge clk);
    send_byte(8'h22);
    send_byte(8'h33);
    close_session("basic");
    check("basic_ram0",     {24'd0, ram[0]},   32'h11);
    check("basic_ram1",     {24'd0, ram[1]},   32'h22);
    check("basic_ram2",     {24'd0, ram[2]},   32'h33);
    check("basic_checksum", {24'd0, checksum}, 32'h66);
    check("basic_acks",     ack_cnt - ack_base, 3);
    check("basic_wes",      we_cnt - we_base,   3);

    // strobe and load_req drop together
    we_base = we_cnt;
    open_session();
    send_byte(8'h05);
    send_byte(8'h07);
    @(negedge clk);
    ui_in = 8'h40; strobe = ~strobe; load_req = 1'b0;
    close_session("same");
    check("same_ram2",     {24'd0, ram[2]},   32'h40);
    check("same_checksum", {24'd0, checksum}, 32'h4C);
    check("same_wes",      we_cnt - we_base,  3);

    // ena gating
    open_session();
    we_base = we_cnt;
    @(negedge clk);
    ena = 1'b0;
    ui_in = 8'h5A; strobe = ~strobe;
    repeat (8) @(negedge clk);
    check("ena_low_no_we", we_cnt - we_base, 0);
    check("ena_low_busy",  {31'd0, busy},    32'd1);
    ena = 1'b1;
    repeat (8) @(negedge clk);
    check("ena_one_we", we_cnt - we_base, 1);
    check("ena_ram0",   {24'd0, ram[0]},  32'h5A);
    close_session("ena");

    // fill RAM past capacity
    we_base = we_cnt; ack_base = ack_cnt;
    open_session();
    for (int i = 0; i < 34; i++) send_byte(8'(i + 1));
    check("full_ram31",    {24'd0, ram[31]},  32'h20);
    check("full_ram0",     {24'd0, ram[0]},   32'h01);
    check("full_overflow", {31'd0, overflow}, 32'd1);
    check("full_addr",     {27'd0, mem_addr}, 32'd31);
    check("full_checksum", {24'd0, checksum}, 32'h10);
    check("full_acks",     ack_cnt - ack_base, 34);
    check("full_wes",      we_cnt - we_base,   32);
    close_session("full");
    check("full_ovf_held", {31'd0, overflow}, 32'd1);

    // reset mid-load
    open_session();
    check("new_session_ovf_clr", {31'd0, overflow}, 32'd0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    @(negedge clk);
    ui_in = 8'hA3; strobe = ~strobe;
    @(negedge clk);
    rst_n = 1'b0; load_req = 1'b0;
    #1;
    check("midrst_hold",     {31'd0, cpu_hold}, 32'd0);
    check("midrst_busy",     {31'd0, busy},     32'd0);
    check("midrst_ack",      {31'd0, ack},      32'd0);
    check("midrst_checksum", {24'd0, checksum}, 32'd0);
    check("midrst_addr",     {27'd0, mem_addr}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_ram0", {24'd0, ram[0]}, 32'hA1);
    check("midrst_ram1", {24'd0, ram[1]}, 32'hA2);
    open_session();
    send_byte(8'hB1);
    close_session("restart");
    check("restart_ram0",     {24'd0, ram[0]},   32'hB1);
    check("restart_ram1",     {24'd0, ram[1]},   32'hA2);
    check("restart_checksum", {24'd0, checksum}, 32'hB1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
